// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_ripple_subtractor_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// Single full-subtractor cell, reused once per bit-cycle by the serial subtractor.
module full_subtractor
    import serial_ripple_subtractor_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ bin;
    assign Bout = (~A & B) | (~(A ^ B) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first,
// framed by a start/busy/done handshake.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_aSr;
    logic [WIDTH-1:0]   r_bSr;
    logic [WIDTH-1:0]   r_resSr;
    logic               r_brw;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_d;
    logic               w_brwNext;
    logic [WIDTH-1:0]   w_resNext;
    logic               w_lastBit;

    full_subtractor u_cell (
        .A    (r_aSr[0]),
        .B    (r_bSr[0]),
        .bin  (r_brw),
        .Diff (w_d),
        .Bout (w_brwNext)
    );

    // A one-bit result register has no upper bits to shift down.
    generate
        if (WIDTH == 1) begin : g_resNarrow
            assign w_resNext = w_d;
        end else begin : g_resWide
            assign w_resNext = {w_d, r_resSr[WIDTH-1:1]};
        end
    endgenerate

    assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_aSr   <= '0;
            r_bSr   <= '0;
            r_resSr <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_aSr   <= a;
                        r_bSr   <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_resSr <= w_resNext;
                    r_aSr   <= r_aSr >> 1;
                    r_bSr   <= r_bSr >> 1;
                    r_brw   <= w_brwNext;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_lastBit) begin
                        r_diff  <= w_resNext;
                        r_bout  <= w_brwNext;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed, table-driven bench for serial_ripple_subtractor (WIDTH=4 and WIDTH=1).
module tb_serial_ripple_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

    int checkCount;
    int errorCount;
    logic [3:0] heldDiff;
    logic       heldBout;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] expDiff;
        logic       expBout;
    } vector_t;

    vector_t vectors[8];

    serial_ripple_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    serial_ripple_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One complete operation on the 4-bit instance, checking every cycle of the frame.
    task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                                 input logic [3:0] expDiff, input logic expBout);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib; bin = ~ibin;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("busy_run", busy, 1);
            checkOutput("done_run", done, 0);
            checkOutput("diff_held", diff, heldDiff);
            checkOutput("bout_held", bout, heldBout);
        end
        @(negedge clk);
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_done", busy, 0);
        checkOutput("diff_result", diff, expDiff);
        checkOutput("bout_result", bout, expBout);
        @(negedge clk);
        checkOutput("done_drop", done, 0);
        checkOutput("busy_idle", busy, 0);
        heldDiff = expDiff;
        heldBout = expBout;
    endtask

    initial begin
        logic [8:0] nv;
        logic [4:0] expFull;

        checkCount = 0;
        errorCount = 0;
        heldDiff   = 4'd0;
        heldBout   = 1'b0;

        vectors[0] = '{a: 4'd9,  b: 4'd5,  bin: 1'b0, expDiff: 4'd4,  expBout: 1'b0};
        vectors[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, expDiff: 4'd14, expBout: 1'b1};
        vectors[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, expDiff: 4'd15, expBout: 1'b1};
        vectors[3] = '{a: 4'd8,  b: 4'd7,  bin: 1'b1, expDiff: 4'd0,  expBout: 1'b0};
        vectors[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, expDiff: 4'd15, expBout: 1'b0};
        vectors[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, expDiff: 4'd0,  expBout: 1'b1};
        vectors[6] = '{a: 4'd15, b: 4'd15, bin: 1'b1, expDiff: 4'd15, expBout: 1'b1};
        vectors[7] = '{a: 4'd7,  b: 4'd7,  bin: 1'b0, expDiff: 4'd0,  expBout: 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_diff", diff, 0);
        checkOutput("rst_bout", bout, 0);
        checkOutput("rst_busy1", busy1, 0);
        checkOutput("rst_done1", done1, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] WIDTH=1 instance");
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("w1_busy", busy1, 1);
        checkOutput("w1_done_run", done1, 0);
        @(negedge clk);
        checkOutput("w1_done", done1, 1);
        checkOutput("w1_busy_done", busy1, 0);
        checkOutput("w1_diff", diff1, 1);
        checkOutput("w1_bout", bout1, 1);
        @(negedge clk);
        checkOutput("w1_done_drop", done1, 0);

        $display("[TB] directed vector table");
        foreach (vectors[i])
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].bin,
                          vectors[i].expDiff, vectors[i].expBout);

        $display("[TB] exhaustive back-to-back");
        @(negedge clk);
        nv = 9'd0;
        a = nv[8:5]; b = nv[4:1]; bin = nv[0]; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 512; n++) begin
            nv = n[8:0];
            expFull = {1'b0, nv[8:5]} - {1'b0, nv[4:1]} - {4'd0, nv[0]};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checkOutput("b2b_busy", busy, 1);
                checkOutput("b2b_done_low", done, 0);
            end
            @(negedge clk);
            checkOutput("b2b_done", done, 1);
            checkOutput("b2b_result", {bout, diff}, expFull);
            if (n < 511) begin
                nv = 9'(n + 1);
                a = nv[8:5]; b = nv[4:1]; bin = nv[0];
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("b2b_end_busy", busy, 0);
        checkOutput("b2b_end_done", done, 0);
        heldDiff = 4'd15;
        heldBout = 1'b1;

        $display("[TB] start ignored while busy");
        @(negedge clk);
        a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("ign_busy", busy, 1);
            checkOutput("ign_diff_held", diff, heldDiff);
            checkOutput("ign_bout_held", bout, heldBout);
            if (i < 3) begin
                start = 1'b1; a = 4'd2; b = 4'd7; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("ign_done", done, 1);
        checkOutput("ign_diff", diff, 4);
        checkOutput("ign_bout", bout, 0);
        @(negedge clk);
        checkOutput("ign_idle_busy", busy, 0);
        checkOutput("ign_idle_done", done, 0);

        $display("[TB] reset mid-run");
        @(negedge clk);
        a = 4'd3; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("abort_busy_before", busy, 1);
        checkOutput("abort_diff_before", diff, 4);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_diff", diff, 0);
        checkOutput("abort_bout", bout, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", done, 0);
            checkOutput("abort_no_busy", busy, 0);
        end
        heldDiff = 4'd0;
        heldBout = 1'b0;
        applyStimulus(4'd9, 4'd5, 1'b0, 4'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
